// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-port sequencer for a multicycle MIPS datapath.
//
// Sits behind the main control FSM. Any of irwrite/iord/memwrite starts one word access to an
// external memory over a req/ack handshake. stall freezes the control FSM until the access has
// completed. Fetched words load the IR (instr), data reads load the MDR (data). A misaligned
// address or a missing ack (TIMEOUT BUSY cycles) sets the sticky bus_err flag. The unit then
// parks in an error state with stall held high until reset.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   pc, aluout            fetch address / data address (iord selects aluout)
//   writedata             store data
//   iord, memwrite,
//   irwrite               access strobes from the control FSM
//   stall                 holds the control FSM state register while high
//   instr, data           IR and MDR contents
//   mem_req, mem_we       memory request and write enable (mem_we valid with mem_req)
//   mem_adr, mem_wdata    address and store data, latched for the whole access
//   mem_rdata, mem_ack    read data and single-cycle completion pulse from memory
//   bus_err               sticky misalignment / timeout flag
module mem_access_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNTW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] aluout,
   input  logic [WIDTH-1:0] writedata,
   input  logic             iord,
   input  logic             memwrite,
   input  logic             irwrite,
   output logic             stall,
   output logic [WIDTH-1:0] instr,
   output logic [WIDTH-1:0] data,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_adr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             bus_err
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone, StErr} state_t;

   state_t           state;
   logic [CNTW-1:0]  cnt;
   logic             fetch;    // latched access type: 1 = instruction fetch
   logic             acc;
   logic [WIDTH-1:0] req_adr;

   assign acc     = irwrite | iord | memwrite;
   assign req_adr = iord ? aluout : pc;

   // stall is combinational so the control FSM is frozen in the very cycle it asks.
   always_comb begin
      stall = 1'b1;
      unique case (state)
         StIdle:  stall = acc;
         StBusy:  stall = 1'b1;
         StDone:  stall = 1'b0;
         StErr:   stall = 1'b1;
         default: stall = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= StIdle;
         cnt       <= '0;
         fetch     <= 1'b0;
         instr     <= '0;
         data      <= '0;
         mem_adr   <= '0;
         mem_wdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (acc) begin
                  if (req_adr[1:0] == 2'b00) begin
                     state     <= StBusy;
                     mem_req   <= 1'b1;
                     mem_adr   <= req_adr;
                     mem_we    <= memwrite;
                     mem_wdata <= writedata;
                     // A store takes precedence over a simultaneous fetch strobe.
                     fetch     <= irwrite & ~memwrite;
                     cnt       <= '0;
                  end else begin
                     state   <= StErr;
                     bus_err <= 1'b1;
                  end
               end
            end
            StBusy: begin
               cnt <= cnt + CNTW'(1);
               // Ack is tested first so an ack on the last allowed cycle still completes.
               if (mem_ack) begin
                  state   <= StDone;
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     if (fetch) instr <= mem_rdata;
                     else       data  <= mem_rdata;
                  end
               end else if (cnt == CNTW'(TIMEOUT - 1)) begin
                  state   <= StErr;
                  mem_req <= 1'b0;
                  bus_err <= 1'b1;
               end
            end
            StDone:  state <= StIdle;
            StErr:   state <= StErr;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. The stimulus thread pushes expected IR/MDR contents (or
// an expected error) into a scoreboard queue. A monitor pops and compares whenever the DUT
// completes an access (stall drops after a request cycle) or raises bus_err.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc, aluout, writedata, mem_rdata;
   logic        iord, memwrite, irwrite, mem_ack;
   logic        stall, mem_req, mem_we, bus_err;
   logic [31:0] instr, data, mem_adr, mem_wdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_err;
      logic [31:0] instr;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   mem_access_unit #(.WIDTH(32), .TIMEOUT(16), .CNTW(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .pc        (pc),
      .aluout    (aluout),
      .writedata (writedata),
      .iord      (iord),
      .memwrite  (memwrite),
      .irwrite   (irwrite),
      .stall     (stall),
      .instr     (instr),
      .data      (data),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_adr   (mem_adr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_done(input logic [31:0] i, input logic [31:0] d);
      exp_t e;
      e.is_err = 1'b0;
      e.instr  = i;
      e.data   = d;
      sb.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.instr  = '0;
      e.data   = '0;
      sb.push_back(e);
   endtask

   task automatic clear_strobes();
      irwrite  = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
   endtask

   // Called just after a rising edge. Drives the request (cycle 0), acks on BUSY cycle ack_at,
   // and returns at the negedge of the DONE cycle.
   task automatic access(input string name, input logic irw, input logic io, input logic mw,
                         input logic [31:0] pcv, input logic [31:0] aluv, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] rd, input logic [31:0] exp_adr);
      irwrite = irw; iord = io; memwrite = mw;
      pc = pcv; aluout = aluv; writedata = wd;
      @(negedge clk);
      chk({name, "_stall_req"}, {31'b0, stall}, 32'd1);
      chk({name, "_noreq_c0"}, {31'b0, mem_req}, 32'd0);
      for (int c = 1; c <= ack_at; c++) begin
         step();
         // Scramble the datapath inputs; the latched address/data must not follow them.
         pc = ~pcv; aluout = ~aluv; writedata = ~wd;
         if (c == ack_at) begin
            mem_ack = 1'b1;
            mem_rdata = rd;
         end
         @(negedge clk);
         chk({name, "_req"}, {31'b0, mem_req}, 32'd1);
         chk({name, "_stall_busy"}, {31'b0, stall}, 32'd1);
         chk({name, "_adr"}, mem_adr, exp_adr);
         chk({name, "_we"}, {31'b0, mem_we}, {31'b0, mw});
         if (mw) chk({name, "_wdata"}, mem_wdata, wd);
      end
      step();
      mem_ack = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      chk({name, "_stall_done"}, {31'b0, stall}, 32'd0);
      chk({name, "_req_done"}, {31'b0, mem_req}, 32'd0);
   endtask

   // Monitor: compares IR/MDR on each completed access and the error flag on its rising edge.
   initial begin
      bit prev_req = 1'b0;
      bit prev_err = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_req = 1'b0;
            prev_err = 1'b0;
         end else begin
            if (prev_req && !stall) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: got completion expected none");
               end else begin
                  e = sb.pop_front();
                  chk("sb_kind_done", 32'd0, {31'b0, e.is_err});
                  chk("sb_instr", instr, e.instr);
                  chk("sb_data", data, e.data);
               end
            end
            if (bus_err && !prev_err) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_err: got bus_err expected none");
               end else begin
                  e = sb.pop_front();
                  chk("sb_kind_err", 32'd1, {31'b0, e.is_err});
               end
            end
            prev_req = mem_req;
            prev_err = bus_err;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; irwrite = 1'b1; iord = 1'b0; memwrite = 1'b0;
      pc = 32'h40; aluout = '0; writedata = '0; mem_rdata = '0; mem_ack = 1'b0;

      // Reset sequencing with a fetch strobe pending.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_instr", instr, 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_we", {31'b0, mem_we}, 32'd0);
      chk("rst_adr", mem_adr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_berr", {31'b0, bus_err}, 32'd0);
      step();
      reset = 1'b1;

      // Zero-wait fetch straight out of reset.
      push_done(32'h8C22_0004, 32'h0);
      access("fetch0", 1, 0, 0, 32'h40, 32'h0, 32'h0, 1, 32'h8C22_0004, 32'h40);
      step(); clear_strobes();

      // lw with 3 wait states (ack on 4th BUSY cycle).
      step();
      push_done(32'h8C22_0004, 32'hDEAD_BEEF);
      access("lw3", 0, 1, 0, 32'h44, 32'h100, 32'h0, 4, 32'hDEAD_BEEF, 32'h100);
      step(); clear_strobes();

      // Store, then back-to-back fetch with no idle gap from the control FSM.
      step();
      push_done(32'h8C22_0004, 32'hDEAD_BEEF);
      access("sw", 0, 1, 1, 32'h48, 32'h200, 32'h1234_5678, 2, 32'hFFFF_FFFF, 32'h200);
      step();
      push_done(32'h0000_0020, 32'hDEAD_BEEF);
      access("fetch_b2b", 1, 0, 0, 32'h4C, 32'h200, 32'h1234_5678, 1, 32'h0000_0020, 32'h4C);
      step(); clear_strobes();

      // Ack on the 16th BUSY cycle beats the timeout.
      step();
      push_done(32'h0000_0020, 32'hCAFE_F00D);
      access("lw16", 0, 1, 0, 32'h50, 32'h300, 32'h0, 16, 32'hCAFE_F00D, 32'h300);
      chk("lw16_berr", {31'b0, bus_err}, 32'd0);
      step(); clear_strobes();

      // Timeout: no ack for 16 BUSY cycles.
      step();
      push_err();
      iord = 1'b1; aluout = 32'h400;
      @(negedge clk);
      for (int c = 1; c <= 16; c++) begin
         step();
         @(negedge clk);
         chk("to_req", {31'b0, mem_req}, 32'd1);
         chk("to_berr_early", {31'b0, bus_err}, 32'd0);
      end
      step(); clear_strobes();
      @(negedge clk);
      chk("to_berr", {31'b0, bus_err}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         step();
         @(negedge clk);
         chk("to_stall_stuck", {31'b0, stall}, 32'd1);
         chk("to_req_low", {31'b0, mem_req}, 32'd0);
      end

      step(); reset = 1'b0;
      step(); reset = 1'b1;
      @(negedge clk);
      chk("rst2_berr", {31'b0, bus_err}, 32'd0);
      chk("rst2_instr", instr, 32'd0);

      // Misaligned data address: immediate error, no request.
      step();
      push_err();
      iord = 1'b1; aluout = 32'h102;
      @(negedge clk);
      chk("mis_stall", {31'b0, stall}, 32'd1);
      for (int c = 0; c < 4; c++) begin
         step();
         @(negedge clk);
         chk("mis_req", {31'b0, mem_req}, 32'd0);
         chk("mis_berr", {31'b0, bus_err}, 32'd1);
         chk("mis_stall_stuck", {31'b0, stall}, 32'd1);
      end
      step(); clear_strobes(); reset = 1'b0;
      step(); reset = 1'b1;

      // Reset in BUSY cycle 2, then a late ack that must be ignored.
      step();
      irwrite = 1'b1; pc = 32'h80;
      step();
      @(negedge clk);
      chk("mid_req_c1", {31'b0, mem_req}, 32'd1);
      step(); reset = 1'b0; clear_strobes();
      @(negedge clk);
      chk("mid_req_c2", {31'b0, mem_req}, 32'd1);
      step(); reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
      @(negedge clk);
      chk("mid_req_after", {31'b0, mem_req}, 32'd0);
      chk("mid_stall_after", {31'b0, stall}, 32'd0);
      step(); mem_ack = 1'b0;
      @(negedge clk);
      chk("mid_instr", instr, 32'd0);
      chk("mid_data", data, 32'd0);
      chk("mid_req_late", {31'b0, mem_req}, 32'd0);

      repeat (2) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
